// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory req/ack bus between fetch unit and memory
interface inst_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - RV32IM fetch stage: PC, imem req/ack, IF/ID register with skid, redirect/flush
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                ip_clk,
    input  logic                ip_rst_n,
    input  logic                ip_stall,
    input  logic                ip_redirect_en,
    input  logic [31:0]         ip_redirect_addr,
    inst_fetch_unit_if.master   imem,
    output logic                op_valid,
    output logic [31:0]         op_pc,
    output logic [31:0]         op_instr,
    output logic [6:0]          op_opcode,
    output logic [2:0]          op_funct_3,
    output logic [6:0]          op_funct_7,
    output logic [4:0]          op_rd,
    output logic [4:0]          op_rs1,
    output logic [4:0]          op_rs2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                op_misalign_trap
`endif
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, addr_q, instr_q, ifid_pc_q, skid_instr_q, skid_pc_q;
    logic        req_q, valid_q;
    logic [31:0] redir_pc;
    logic        ifid_free;
    logic        trap_d;

    // Masking keeps every redirect bit in use whether or not the trap is built.
    assign redir_pc  = ip_redirect_addr & ~32'h0000_0003;
    assign ifid_free = !valid_q || !ip_stall;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;
    assign trap_d = ip_redirect_en ? (ip_redirect_addr[1:0] != 2'b00) : trap_q;

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) trap_q <= 1'b0;
        else           trap_q <= trap_d;
    end

    assign op_misalign_trap = trap_q;
`else
    assign trap_d = 1'b0;
`endif

    // Skid contents are meaningful only while in S_HOLD.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= NOP;
            ifid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else if (ip_redirect_en) begin
            pc_q    <= redir_pc;
            valid_q <= 1'b0;
            if (req_q && !imem.ack) begin
                state_q <= S_DROP;
            end else begin
                state_q <= S_FETCH;
                req_q   <= !trap_d;
                addr_q  <= redir_pc;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= !trap_d;
                    addr_q  <= pc_q;
                end
                S_FETCH: begin
                    if (valid_q && !ip_stall) valid_q <= 1'b0;
                    if (req_q && imem.ack) begin
                        pc_q <= pc_q + PC_INC;
                        if (ifid_free) begin
                            instr_q   <= imem.rdata;
                            ifid_pc_q <= pc_q;
                            valid_q   <= 1'b1;
                            addr_q    <= pc_q + PC_INC;
                        end else begin
                            skid_instr_q <= imem.rdata;
                            skid_pc_q    <= pc_q;
                            req_q        <= 1'b0;
                            state_q      <= S_HOLD;
                        end
                    end else if (!req_q && !trap_d) begin
                        req_q  <= 1'b1;
                        addr_q <= pc_q;
                    end
                end
                S_HOLD: begin
                    if (!ip_stall) begin
                        instr_q   <= skid_instr_q;
                        ifid_pc_q <= skid_pc_q;
                        valid_q   <= 1'b1;
                        state_q   <= S_FETCH;
                        req_q     <= !trap_d;
                        addr_q    <= pc_q;
                    end
                end
                S_DROP: begin
                    if (imem.ack) begin
                        state_q <= S_FETCH;
                        req_q   <= !trap_d;
                        addr_q  <= pc_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem.req   = req_q;
    assign imem.addr  = addr_q;
    assign op_valid   = valid_q;
    assign op_pc      = ifid_pc_q;
    assign op_instr   = instr_q;
    assign op_opcode  = instr_q[6:0];
    assign op_funct_3 = instr_q[14:12];
    assign op_funct_7 = instr_q[31:25];
    assign op_rd      = instr_q[11:7];
    assign op_rs1     = instr_q[19:15];
    assign op_rs2     = instr_q[24:20];
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir_en;
    logic [31:0] redir_addr;
    logic        valid;
    logic [31:0] pc, instr;
    logic [6:0]  opcode, funct_7;
    logic [2:0]  funct_3;
    logic [4:0]  rd, rs1, rs2;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap;
`endif

    inst_fetch_unit_if imem_if();

    int          tests = 0;
    int          fails = 0;
    int          lat = 1;
    bit          mem_en = 1'b1;
    int          wait_cnt;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .ip_clk           (clk),
        .ip_rst_n         (rst_n),
        .ip_stall         (stall),
        .ip_redirect_en   (redir_en),
        .ip_redirect_addr (redir_addr),
        .imem             (imem_if),
        .op_valid         (valid),
        .op_pc            (pc),
        .op_instr         (instr),
        .op_opcode        (opcode),
        .op_funct_3       (funct_3),
        .op_funct_7       (funct_7),
        .op_rd            (rd),
        .op_rs1           (rs1),
        .op_rs2           (rs2)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .op_misalign_trap (trap)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0073_0293;
            32'h0000_0004: return 32'h4020_81B3;
            default:       return {a[15:0], 16'h0033};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory: ack `lat` cycles after it first sees a request, one-cycle ack pulse.
    initial begin
        imem_if.ack   = 1'b0;
        imem_if.rdata = 32'h0;
        wait_cnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_if.ack) begin
                imem_if.ack = 1'b0;
                wait_cnt    = 0;
            end else if (imem_if.req === 1'b1 && mem_en) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    imem_if.ack   = 1'b1;
                    imem_if.rdata = mem_word(imem_if.addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: each cycle with a valid, unstalled IF/ID entry is one delivered instruction.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst_n === 1'b1 && valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr actual pc=%h instr=%h required=none", pc, instr);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e[63:32]);
                check("sb_instr", instr, e[31:0]);
                check("sb_fields", {opcode, funct_3, funct_7, rd, rs1, rs2},
                      {e[6:0], e[14:12], e[31:25], e[11:7], e[19:15], e[24:20]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir_en = 1'b0; redir_addr = 32'h0;
        repeat (3) tick();
        check("rst_req",   32'(imem_if.req), 32'h0);
        check("rst_addr",  imem_if.addr,     32'h0);
        check("rst_valid", 32'(valid),       32'h0);
        check("rst_instr", instr,            32'h0000_0013);
        check("rst_pc",    pc,               32'h0);

        exp_q.push_back({32'h0, 32'h0073_0293});
        exp_q.push_back({32'h4, 32'h4020_81B3});
        rst_n = 1'b1;
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick();
        stall = 1'b1;
        check("first_valid",  32'(valid),   32'h1);
        check("first_pc",     pc,           32'h0);
        check("first_opcode", 32'(opcode),  32'h13);
        check("first_funct3", 32'(funct_3), 32'h0);
        check("first_rd",     32'(rd),      32'h5);
        check("first_rs1",    32'(rs1),     32'h6);
        check("first_rs2",    32'(rs2),     32'h7);
        check("next_addr",    imem_if.addr, 32'h4);

        for (int n = 0; n < 20 && imem_if.req !== 1'b0; n++) tick();
        check("hold_req",   32'(imem_if.req), 32'h0);
        check("hold_pc",    pc,               32'h0);
        check("hold_valid", 32'(valid),       32'h1);
        repeat (2) tick();
        check("hold_req_2", 32'(imem_if.req), 32'h0);
        check("hold_instr", instr,            32'h0073_0293);

        lat = 3;
        stall = 1'b0;
        for (int n = 0; n < 20 && pc !== 32'h4; n++) tick();
        check("skid_pc",     pc,               32'h4);
        check("skid_valid",  32'(valid),       32'h1);
        check("skid_funct7", 32'(funct_7),     32'h20);
        check("skid_rd",     32'(rd),          32'h3);
        check("skid_rs1",    32'(rs1),         32'h1);
        check("skid_rs2",    32'(rs2),         32'h2);
        check("skid_next",   imem_if.addr,     32'h8);
        check("skid_req",    32'(imem_if.req), 32'h1);

        exp_q.push_back({32'h100, mem_word(32'h100)});
        redir_en = 1'b1; redir_addr = 32'h100;
        tick();
        redir_en = 1'b0;
        check("redir_flush", 32'(valid),       32'h0);
        check("drop_addr",   imem_if.addr,     32'h8);
        check("drop_req",    32'(imem_if.req), 32'h1);
        for (int n = 0; n < 20 && imem_if.addr !== 32'h100; n++) tick();
        check("redir_addr", imem_if.addr, 32'h100);
        lat = 1;
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick();
        check("redir_pc", pc, 32'h100);

        for (int n = 0; n < 20 && imem_if.ack !== 1'b1; n++) tick();
        exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        redir_en = 1'b1; redir_addr = 32'hFFFF_FFFC;
        tick();
        redir_en = 1'b0;
        check("ackredir_flush", 32'(valid),   32'h0);
        check("ackredir_addr",  imem_if.addr, 32'hFFFF_FFFC);
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick();
        check("wrap_pc",   pc,               32'hFFFF_FFFC);
        check("wrap_addr", imem_if.addr,     32'h0);
        mem_en = 1'b0;
        repeat (3) tick();
        check("park_req",  32'(imem_if.req), 32'h1);
        check("park_addr", imem_if.addr,     32'h0);

        mem_en = 1'b1;
        redir_en = 1'b1; redir_addr = 32'h102;
        tick();
        redir_en = 1'b0;
        check("mis_drop_addr", imem_if.addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int n = 0; n < 20 && imem_if.req !== 1'b0; n++) tick();
        check("trap_set", 32'(trap), 32'h1);
        repeat (3) tick();
        check("trap_no_req", 32'(imem_if.req), 32'h0);
        exp_q.push_back({32'h200, mem_word(32'h200)});
        redir_en = 1'b1; redir_addr = 32'h200;
        tick();
        redir_en = 1'b0;
        check("trap_clear", 32'(trap),        32'h0);
        check("trap_req",   32'(imem_if.req), 32'h1);
        check("trap_addr",  imem_if.addr,     32'h200);
`else
        exp_q.push_back({32'h100, mem_word(32'h100)});
        for (int n = 0; n < 20 && imem_if.addr !== 32'h100; n++) tick();
        check("mis_addr", imem_if.addr,     32'h100);
        check("mis_req",  32'(imem_if.req), 32'h1);
`endif
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick();
        mem_en = 1'b0;
        repeat (5) tick();
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        check("end_valid", 32'(valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
